// File: rtl/pipe_adder_pkg.sv
// Shared types and configuration checks for the pipelined adder/subtractor.
// The payload struct is everything one operation carries between register stages.
package pipe_adder_pkg;

  // Widest datapath the payload struct can carry; narrower instances zero-extend.
  localparam int unsigned PAYLOAD_WIDTH = 64;

  typedef struct packed {
    logic                     carry;     // carry into the next chunk
    logic                     zero_acc;  // AND of the zero bits of chunks produced so far
    logic                     sub;       // operation tag, kept for the whole flight
    logic [PAYLOAD_WIDTH-1:0] sum;       // result chunks computed so far
    logic [PAYLOAD_WIDTH-1:0] a;         // operand a
    logic [PAYLOAD_WIDTH-1:0] b;         // operand b, already inverted for subtract
  } payload_t;

  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0)
        && (width <= PAYLOAD_WIDTH);
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One pipeline stage: adds operand chunk IDX plus the incoming carry, folds the
// chunk's zero bit into the accumulator and registers the payload under ready/valid.
module adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4,
  parameter int unsigned IDX    = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_payload,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_payload
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned LSB   = IDX * CHUNK;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             carry_next;
  payload_t         next_payload;

  assign a_chunk = in_payload.a[LSB +: CHUNK];
  assign b_chunk = in_payload.b[LSB +: CHUNK];

  // The only carry chain between registers: CHUNK bits wide.
  assign {carry_next, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk}
                                 + {{CHUNK{1'b0}}, in_payload.carry};

  always_comb begin
    // NOTE: start from a full default so every field is assigned on every path and no latch is inferred.
    next_payload                    = in_payload;
    next_payload.carry              = carry_next;
    next_payload.zero_acc           = in_payload.zero_acc & (sum_chunk == '0);
    next_payload.sum[LSB +: CHUNK]  = sum_chunk;
  end

  // A stage may take new data when it is empty or its contents move on this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      // NOTE: the payload is reset as well so the flag outputs read 0, not X, right after reset.
      out_payload <= '0;
    end else if (in_ready) begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
      out_valid <= in_valid;
      if (in_valid) begin
        out_payload <= next_payload;
      end
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor with ready/valid on both sides.
// Top level: operand preparation, the stage chain, and the result flags.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of STAGES and fit the payload");
  end

  payload_t head_payload;
  payload_t last;

  // Subtract is a + ~b + 1: invert b here and seed the carry chain with 1.
  always_comb begin
    head_payload          = '0;
    head_payload.carry    = sub;
    head_payload.zero_acc = 1'b1;
    head_payload.sub      = sub;
    head_payload.a        = PAYLOAD_WIDTH'(a);
    head_payload.b        = PAYLOAD_WIDTH'(sub ? ~b : b);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    payload_t up_payload;
    payload_t q;
    logic     up_valid;
    logic     up_ready;
    logic     valid;
    logic     down_ready;

    if (k == 0) begin : g_head
      assign up_payload = head_payload;
      assign up_valid   = in_valid;
    end else begin : g_link
      assign up_payload = g_stage[k-1].q;
      assign up_valid   = g_stage[k-1].valid;
    end

    if (k == STAGES - 1) begin : g_tail
      assign down_ready = out_ready;
    end else begin : g_next
      assign down_ready = g_stage[k+1].up_ready;
    end

    adder_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (up_valid),
      .in_ready    (up_ready),
      .in_payload  (up_payload),
      .out_valid   (valid),
      .out_ready   (down_ready),
      .out_payload (q)
    );
  end

  assign in_ready  = g_stage[0].up_ready;
  assign last      = g_stage[STAGES-1].q;
  assign out_valid = g_stage[STAGES-1].valid;

  // Flags come straight from the final register, so no input reaches an output combinationally.
  assign sum       = last.sum[WIDTH-1:0];
  assign carry_out = last.carry;
  assign zero      = last.zero_acc;
  assign overflow  = (last.a[WIDTH-1] == last.b[WIDTH-1]) && (last.sum[WIDTH-1] != last.a[WIDTH-1]);

  // Operand tails and the sub tag are carried but not needed once the last chunk is done.
  logic unused_payload_bits;
  assign unused_payload_bits = ^{last.sub, last.a, last.b, last.sum};

  property p_stall_hold;
    @(posedge clk) disable iff (!rst_n)
      out_valid && !out_ready |=> out_valid && $stable(sum) && $stable(carry_out)
                                  && $stable(overflow) && $stable(zero);
  endproperty
  a_stall_hold: assert property (p_stall_hold);

endmodule
